// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, reads words from imem and buffers them for the datapath.
// Optional FETCH_PERF_CNT_EN adds a saturating bubble counter output (fetch_bubble_cnt).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        clear,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_bubble_cnt,
`endif
    input  logic        instr_ready
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DROP
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_data_q [BUF_DEPTH];

    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   redir_al;
    logic [31:0]   fpc_inc;
    logic [CW-1:0] cnt_pop;
    logic [CW-1:0] cnt_push_pop;

    assign instr_valid  = (cnt_q != '0);
    assign instr        = buf_data_q[rd_ptr_q];
    assign instr_pc     = buf_pc_q[rd_ptr_q];
    assign imem_req     = req_q;
    assign imem_addr    = addr_q;

    assign pop          = instr_valid & instr_ready & ~redirect_valid;
    assign redir_al     = redirect_pc & 32'hFFFF_FFFC;
    assign fpc_inc      = fpc_q + 32'd4;
    assign cnt_pop      = cnt_q - CW'(pop);
    assign cnt_push_pop = cnt_q + CW'(1) - CW'(pop);

    // Request gating uses post-pop occupancy so the buffer never overflows.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    fpc_d = redir_al;
                end else if (cnt_pop < DEPTH_C) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    addr_d  = fpc_q;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    fpc_d = redir_al;
                    if (imem_ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (imem_ack) begin
                    push  = 1'b1;
                    fpc_d = fpc_inc;
                    if (cnt_push_pop < DEPTH_C) begin
                        addr_d = fpc_inc;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            S_DROP: begin
                // Stale request stays on the bus until memory completes it.
                if (redirect_valid) begin
                    flush = 1'b1;
                    fpc_d = redir_al;
                end
                if (imem_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            req_q    <= 1'b0;
            addr_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_q[i]   <= '0;
                buf_data_q[i] <= '0;
            end
        end else if (push) begin
            buf_pc_q[wr_ptr_q]   <= fpc_q;
            buf_data_q[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        bubble_d = bubble_q;
        if (instr_ready && !instr_valid && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_d = bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            bubble_q <= '0;
        end else begin
            bubble_q <= bubble_d;
        end
    end

    assign fetch_bubble_cnt = bubble_q;
`endif

endmodule
